// File: rtl/control_unit_pkg.sv
// control_unit_pkg: shared definitions for the PoliRISC-V multicycle control unit.
// Holds FSM state encodings, RV32I/RV64I major opcodes, writeback mux codes,
// the decode classifier and the branch condition helper.
package control_unit_pkg;

    localparam int unsigned STATE_W = 4;

    typedef enum logic [STATE_W-1:0] {
        S_IDLE    = 4'd0,
        S_FETCH   = 4'd1,
        S_DECODE  = 4'd2,
        S_REG_REG = 4'd3,
        S_LUI     = 4'd4,
        S_REG_IMM = 4'd5,
        S_AUIPC   = 4'd6,
        S_JAL     = 4'd7,
        S_BRANCH  = 4'd8,
        S_JALR    = 4'd9,
        S_LOAD    = 4'd10,
        S_STORE   = 4'd11,
        S_HALT    = 4'd12
    } state_t;

    localparam logic [6:0] OPC_LOAD      = 7'b0000011;
    localparam logic [6:0] OPC_OP_IMM    = 7'b0010011;
    localparam logic [6:0] OPC_AUIPC     = 7'b0010111;
    localparam logic [6:0] OPC_OP_IMM_32 = 7'b0011011;
    localparam logic [6:0] OPC_STORE     = 7'b0100011;
    localparam logic [6:0] OPC_OP        = 7'b0110011;
    localparam logic [6:0] OPC_LUI       = 7'b0110111;
    localparam logic [6:0] OPC_OP_32     = 7'b0111011;
    localparam logic [6:0] OPC_BRANCH    = 7'b1100011;
    localparam logic [6:0] OPC_JALR      = 7'b1100111;
    localparam logic [6:0] OPC_JAL       = 7'b1101111;

    localparam logic [1:0] WR_SRC_MEM = 2'b00;
    localparam logic [1:0] WR_SRC_PC4 = 2'b01;
    localparam logic [1:0] WR_SRC_ALU = 2'b10;

    // Map an instruction to its execute state; anything not executable here goes to HALT.
    function automatic state_t decode_opcode(input logic [6:0] opcode,
                                             input logic [2:0] funct3,
                                             input logic       rv64);
        state_t s;
        s = S_HALT;
        if (opcode[1:0] == 2'b11) begin
            case (opcode)
                OPC_OP:        s = S_REG_REG;
                OPC_OP_32:     s = rv64 ? S_REG_REG : S_HALT;
                OPC_OP_IMM:    s = S_REG_IMM;
                OPC_OP_IMM_32: s = rv64 ? S_REG_IMM : S_HALT;
                OPC_LUI:       s = S_LUI;
                OPC_AUIPC:     s = S_AUIPC;
                OPC_JAL:       s = S_JAL;
                OPC_JALR:      s = S_JALR;
                OPC_BRANCH:    s = (funct3[2:1] == 2'b01) ? S_HALT : S_BRANCH;
                OPC_LOAD:      s = (!rv64 && (funct3 == 3'b011 || funct3 == 3'b110)) ? S_HALT : S_LOAD;
                OPC_STORE:     s = (!rv64 && funct3 == 3'b011) ? S_HALT : S_STORE;
                default:       s = S_HALT;
            endcase
        end
        return s;
    endfunction

    // Branch condition from the subtract flags; funct3[0] inverts the base test.
    function automatic logic branch_cond(input logic [2:0] funct3,
                                         input logic       zero,
                                         input logic       negative,
                                         input logic       carry_out,
                                         input logic       overflow);
        logic c;
        c = 1'b0;
        case (funct3[2:1])
            2'b00:   c = zero ^ funct3[0];
            2'b10:   c = (negative ^ overflow) ^ funct3[0];
            2'b11:   c = carry_out ~^ funct3[0];
            default: c = 1'b0;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/mem_handshake.sv
// mem_handshake: tracks a busy-then-idle memory handshake while its state is active.
// Ports: clock, reset (sync, active-low), active (owning state is current),
// busy (memory busy), done (exit this cycle), seen_busy (busy observed so far),
// timeout (only with CONTROL_UNIT_MEM_TIMEOUT_EN: cycle limit reached).
module mem_handshake
`ifdef CONTROL_UNIT_MEM_TIMEOUT_EN
#(
    parameter int unsigned TIMEOUT_CYCLES = 255
)
`endif
(
    input  logic clock,
    input  logic reset,
    input  logic active,
    input  logic busy,
    output logic done,
    output logic seen_busy
`ifdef CONTROL_UNIT_MEM_TIMEOUT_EN
    ,
    output logic timeout
`endif
);

    logic leave;

    // Busy seen on an earlier edge and now dropped: the access has completed.
    assign done = active & seen_busy & ~busy;

`ifdef CONTROL_UNIT_MEM_TIMEOUT_EN
    localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [CNT_W-1:0] count;

    // Fires during the last allowed cycle so the state spends exactly TIMEOUT_CYCLES cycles.
    assign timeout = active & ~done & (count == CNT_W'(TIMEOUT_CYCLES - 1));
    assign leave   = done | timeout;

    always_ff @(posedge clock) begin
        if (!reset) begin
            count <= '0;
        end else if (!active || leave) begin
            count <= '0;
        end else begin
            count <= count + CNT_W'(1);
        end
    end
`else
    assign leave = done;
`endif

    always_ff @(posedge clock) begin
        if (!reset) begin
            seen_busy <= 1'b0;
        end else if (!active || leave) begin
            seen_busy <= 1'b0;
        end else if (busy) begin
            seen_busy <= 1'b1;
        end
    end

endmodule

// File: rtl/control_unit_param.sv
// control_unit_param: multicycle control FSM for the PoliRISC-V RV32I/RV64I core.
// Optional handshake timeout enabled by defining CONTROL_UNIT_MEM_TIMEOUT_EN.
// Ports: clock/reset (sync, active-low); opcode/funct3/funct7 instruction fields;
// instruction/data memory enable+busy handshakes and store byte lanes;
// ALU flags in; datapath selects/enables out; illegal_instruction and
// mem_timeout sticky status flags.
module control_unit_param
    import control_unit_pkg::*;
#(
    parameter int unsigned DATA_SIZE      = 64,
    parameter int unsigned BYTE_NUM       = DATA_SIZE / 8,
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic                clock,
    input  logic                reset,
    input  logic [6:0]          opcode,
    input  logic [2:0]          funct3,
    input  logic [6:0]          funct7,
    input  logic                instruction_mem_busy,
    output logic                instruction_mem_enable,
    input  logic                data_mem_busy,
    output logic                data_mem_enable,
    output logic [BYTE_NUM-1:0] data_mem_byte_write_enable,
    input  logic                zero,
    input  logic                negative,
    input  logic                carry_out,
    input  logic                overflow,
    output logic                alua_src,
    output logic                alub_src,
    output logic                aluy_src,
    output logic [2:0]          alu_src,
    output logic                carry_in,
    output logic                arithmetic,
    output logic                alupc_src,
    output logic                pc_src,
    output logic                pc_enable,
    output logic [2:0]          read_data_src,
    output logic [1:0]          write_register_src,
    output logic                write_register_enable,
    output logic                illegal_instruction,
    output logic                mem_timeout
);

    localparam bit IS_RV64 = (DATA_SIZE == 64);

    state_t      state;
    state_t      next_state;
    logic        fetch_active;
    logic        data_active;
    logic        fetch_done;
    logic        data_done;
    logic        fetch_seen_busy;
    logic        data_seen_busy;
    logic        fetch_timeout;
    logic        data_timeout;
    logic [15:0] store_mask;
    logic        unused_bits;

    assign fetch_active = (state == S_FETCH);
    assign data_active  = (state == S_LOAD) || (state == S_STORE);

    // Instruction-side handshake
    mem_handshake
`ifdef CONTROL_UNIT_MEM_TIMEOUT_EN
        #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES))
`endif
    u_fetch_hs (
        .clock     (clock),
        .reset     (reset),
        .active    (fetch_active),
        .busy      (instruction_mem_busy),
        .done      (fetch_done),
        .seen_busy (fetch_seen_busy)
`ifdef CONTROL_UNIT_MEM_TIMEOUT_EN
        ,
        .timeout   (fetch_timeout)
`endif
    );

    // Data-side handshake shared by LOAD and STORE
    mem_handshake
`ifdef CONTROL_UNIT_MEM_TIMEOUT_EN
        #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES))
`endif
    u_data_hs (
        .clock     (clock),
        .reset     (reset),
        .active    (data_active),
        .busy      (data_mem_busy),
        .done      (data_done),
        .seen_busy (data_seen_busy)
`ifdef CONTROL_UNIT_MEM_TIMEOUT_EN
        ,
        .timeout   (data_timeout)
`endif
    );

`ifdef CONTROL_UNIT_MEM_TIMEOUT_EN
    // Sticky until reset once any handshake runs out of time
    always_ff @(posedge clock) begin
        if (!reset) begin
            mem_timeout <= 1'b0;
        end else if (fetch_timeout || data_timeout) begin
            mem_timeout <= 1'b1;
        end
    end
`else
    localparam int unsigned unused_timeout_cycles = TIMEOUT_CYCLES;
    assign fetch_timeout = 1'b0;
    assign data_timeout  = 1'b0;
    assign mem_timeout   = 1'b0;
`endif

    assign unused_bits = ^{funct7[6], funct7[4:0], fetch_seen_busy, data_seen_busy};

    // State register
    always_ff @(posedge clock) begin
        if (!reset) begin
            state <= S_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Sticky decode fault flag
    always_ff @(posedge clock) begin
        if (!reset) begin
            illegal_instruction <= 1'b0;
        end else if (state == S_DECODE && next_state == S_HALT) begin
            illegal_instruction <= 1'b1;
        end
    end

    // Next-state logic
    always_comb begin
        next_state = state;
        case (state)
            S_IDLE:   next_state = S_FETCH;
            S_FETCH: begin
                if (fetch_done) begin
                    next_state = S_DECODE;
                end else if (fetch_timeout) begin
                    next_state = S_HALT;
                end
            end
            S_DECODE: next_state = decode_opcode(opcode, funct3, IS_RV64);
            S_REG_REG, S_REG_IMM, S_LUI, S_AUIPC,
            S_JAL, S_JALR, S_BRANCH:
                      next_state = S_FETCH;
            S_LOAD, S_STORE: begin
                if (data_done) begin
                    next_state = S_FETCH;
                end else if (data_timeout) begin
                    next_state = S_HALT;
                end
            end
            S_HALT:   next_state = S_HALT;
            default:  next_state = S_IDLE;
        endcase
    end

    // Output decode from the registered state and the live instruction fields
    always_comb begin
        instruction_mem_enable     = 1'b0;
        data_mem_enable            = 1'b0;
        data_mem_byte_write_enable = '0;
        alua_src                   = 1'b0;
        alub_src                   = 1'b0;
        aluy_src                   = 1'b0;
        alu_src                    = 3'b000;
        carry_in                   = 1'b0;
        arithmetic                 = 1'b0;
        alupc_src                  = 1'b0;
        pc_src                     = 1'b0;
        pc_enable                  = 1'b0;
        read_data_src              = 3'b000;
        write_register_src         = WR_SRC_MEM;
        write_register_enable      = 1'b0;
        // 1, 2, 4 or 8 lanes from the access size in funct3[1:0]
        store_mask                 = (16'd1 << (5'd1 << funct3[1:0])) - 16'd1;

        case (state)
            S_FETCH: instruction_mem_enable = 1'b1;
            S_REG_REG: begin
                alub_src              = 1'b1;
                aluy_src              = opcode[3];
                alu_src               = funct3;
                carry_in              = funct7[5];
                arithmetic            = funct7[5];
                write_register_src    = WR_SRC_ALU;
                write_register_enable = 1'b1;
                pc_enable             = 1'b1;
            end
            S_REG_IMM: begin
                aluy_src              = opcode[3];
                alu_src               = funct3;
                arithmetic            = funct7[5] & (funct3 == 3'b101);
                write_register_src    = WR_SRC_ALU;
                write_register_enable = 1'b1;
                pc_enable             = 1'b1;
            end
            S_LUI: begin
                aluy_src              = 1'b1;
                write_register_src    = WR_SRC_ALU;
                write_register_enable = 1'b1;
                pc_enable             = 1'b1;
            end
            S_AUIPC: begin
                alua_src              = 1'b1;
                write_register_src    = WR_SRC_ALU;
                write_register_enable = 1'b1;
                pc_enable             = 1'b1;
            end
            S_JAL, S_JALR: begin
                alupc_src             = (state == S_JALR);
                pc_src                = 1'b1;
                write_register_src    = WR_SRC_PC4;
                write_register_enable = 1'b1;
                pc_enable             = 1'b1;
            end
            S_BRANCH: begin
                alub_src  = 1'b1;
                carry_in  = 1'b1;
                pc_src    = branch_cond(funct3, zero, negative, carry_out, overflow);
                pc_enable = 1'b1;
            end
            S_LOAD: begin
                data_mem_enable       = 1'b1;
                read_data_src         = funct3 ^ 3'b100;
                write_register_enable = data_done;
                pc_enable             = data_done;
            end
            S_STORE: begin
                data_mem_enable            = 1'b1;
                data_mem_byte_write_enable = BYTE_NUM'(store_mask);
                pc_enable                  = data_done;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_control_unit_param.sv
// tb_control_unit_param: scoreboard bench for control_unit_param.
// A driver issues instructions with randomized handshakes and pushes the
// expected retire cycle and control word; a monitor pops on every pc_enable.
// A second RV32 instance covers width-dependent legality and the timeout build.
module tb_control_unit_param;
    import control_unit_pkg::*;

    typedef struct {
        int          cycle;
        logic [31:0] vec;
    } exp_t;

    exp_t sb[$];
    int   total = 0;
    int   bad   = 0;
    int   cyc   = 0;

    logic       clock;
    logic       reset;
    logic [6:0] opcode;
    logic [2:0] funct3;
    logic [6:0] funct7;
    logic       imem_busy, dmem_busy;
    logic       zero, negative, carry_out, overflow;

    logic       imem_en, dmem_en;
    logic [7:0] bwe;
    logic       alua, alub, aluy, cin, arith, alupc, pcs, pce, wre, illegal, mtimeout;
    logic [2:0] alu, rds;
    logic [1:0] wsrc;

    logic       reset32, imem_busy32, dmem_busy32;
    logic       imem_en32, dmem_en32;
    logic [3:0] bwe32;
    logic       alua32, alub32, aluy32, cin32, arith32, alupc32, pcs32, pce32, wre32;
    logic       illegal32, mtimeout32;
    logic [2:0] alu32, rds32;
    logic [1:0] wsrc32;

    initial clock = 1'b0;
    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    control_unit_param dut (
        .clock(clock), .reset(reset), .opcode(opcode), .funct3(funct3), .funct7(funct7),
        .instruction_mem_busy(imem_busy), .instruction_mem_enable(imem_en),
        .data_mem_busy(dmem_busy), .data_mem_enable(dmem_en),
        .data_mem_byte_write_enable(bwe),
        .zero(zero), .negative(negative), .carry_out(carry_out), .overflow(overflow),
        .alua_src(alua), .alub_src(alub), .aluy_src(aluy), .alu_src(alu),
        .carry_in(cin), .arithmetic(arith), .alupc_src(alupc), .pc_src(pcs),
        .pc_enable(pce), .read_data_src(rds), .write_register_src(wsrc),
        .write_register_enable(wre), .illegal_instruction(illegal), .mem_timeout(mtimeout)
    );

    control_unit_param #(.DATA_SIZE(32), .TIMEOUT_CYCLES(8)) dut32 (
        .clock(clock), .reset(reset32), .opcode(opcode), .funct3(funct3), .funct7(funct7),
        .instruction_mem_busy(imem_busy32), .instruction_mem_enable(imem_en32),
        .data_mem_busy(dmem_busy32), .data_mem_enable(dmem_en32),
        .data_mem_byte_write_enable(bwe32),
        .zero(zero), .negative(negative), .carry_out(carry_out), .overflow(overflow),
        .alua_src(alua32), .alub_src(alub32), .aluy_src(aluy32), .alu_src(alu32),
        .carry_in(cin32), .arithmetic(arith32), .alupc_src(alupc32), .pc_src(pcs32),
        .pc_enable(pce32), .read_data_src(rds32), .write_register_src(wsrc32),
        .write_register_enable(wre32), .illegal_instruction(illegal32), .mem_timeout(mtimeout32)
    );

    function automatic logic [31:0] obs64();
        return 32'({imem_en, dmem_en, bwe, alua, alub, aluy, alu, cin, arith, alupc, pcs, rds, wsrc, wre});
    endfunction

    // Reference control word at the retire cycle, straight from the ISA-level rules
    function automatic logic [31:0] model(input logic [6:0] op, input logic [2:0] f3,
                                          input logic [6:0] f7, input logic [3:0] flags);
        logic       dme, a_a, a_b, a_y, ci, ar, apc, ps, we, base;
        logic [7:0] be;
        logic [2:0] al, rd;
        logic [1:0] ws;
        logic       z, n, c, v;
        {z, n, c, v} = flags;
        dme = 0; a_a = 0; a_b = 0; a_y = 0; ci = 0; ar = 0; apc = 0; ps = 0; we = 0;
        be = 8'h00; al = 3'd0; rd = 3'd0; ws = 2'd0; base = 0;
        if (op == OPC_OP || op == OPC_OP_32) begin
            a_b = 1; a_y = (op == OPC_OP_32); al = f3; ci = f7[5]; ar = f7[5]; ws = 2'd2; we = 1;
        end else if (op == OPC_OP_IMM || op == OPC_OP_IMM_32) begin
            a_y = (op == OPC_OP_IMM_32); al = f3; ar = f7[5] && (f3 == 3'd5); ws = 2'd2; we = 1;
        end else if (op == OPC_LUI) begin
            a_y = 1; ws = 2'd2; we = 1;
        end else if (op == OPC_AUIPC) begin
            a_a = 1; ws = 2'd2; we = 1;
        end else if (op == OPC_JAL || op == OPC_JALR) begin
            ps = 1; apc = (op == OPC_JALR); ws = 2'd1; we = 1;
        end else if (op == OPC_BRANCH) begin
            a_b = 1; ci = 1;
            if (f3[2:1] == 2'b00) base = z;           // equal
            else if (f3[2:1] == 2'b10) base = n ^ v;  // signed less-than
            else base = !c;                            // unsigned less-than: borrow
            ps = f3[0] ? !base : base;
        end else if (op == OPC_LOAD) begin
            dme = 1; rd = f3 ^ 3'b100; we = 1;
        end else if (op == OPC_STORE) begin
            dme = 1;
            case (f3[1:0])
                2'd0: be = 8'h01;
                2'd1: be = 8'h03;
                2'd2: be = 8'h0F;
                default: be = 8'hFF;
            endcase
        end
        return 32'({1'b0, dme, be, a_a, a_b, a_y, al, ci, ar, apc, ps, rd, ws, we});
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    // Scoreboard monitor: every retire must match the oldest expectation
    always @(negedge clock) begin : monitor
        exp_t e;
        if (reset === 1'b1 && pce === 1'b1) begin
            total++;
            if (sb.size() == 0) begin
                bad++;
                $display("FAIL retire_unexpected: got pc_enable at cycle %0d want none", cyc);
            end else begin
                e = sb.pop_front();
                if (obs64() !== e.vec || cyc != e.cycle) begin
                    bad++;
                    $display("FAIL retire: got word %0h cycle %0d want word %0h cycle %0d",
                             obs64(), cyc, e.vec, e.cycle);
                end
            end
        end
    end

    task automatic wait_fetch(input int limit);
        int n;
        n = 0;
        while (imem_en !== 1'b1 && n < limit) begin
            @(posedge clock); #1;
            n++;
        end
        check("fetch_reached", 64'(imem_en), 64'(1));
    endtask

    task automatic do_reset();
        reset = 0; imem_busy = 0; dmem_busy = 0;
        repeat (3) @(posedge clock);
        #1;
        check("reset_outputs", 64'({obs64(), pce, illegal, mtimeout}), 64'(0));
        reset = 1;
        @(posedge clock); #1;
        check("fetch_after_release", 64'({imem_en, dmem_en, pce}), 64'(3'b100));
    endtask

    task automatic issue(input logic [6:0] op, input logic [2:0] f3, input logic [6:0] f7,
                         input logic [3:0] flags, input int pre, input int hi,
                         input int dpre, input int dhi);
        exp_t e;
        int   f, m;
        logic mem;
        wait_fetch(0);
        opcode = op; funct3 = f3; funct7 = f7;
        {zero, negative, carry_out, overflow} = flags;
        f   = pre + hi + 1;
        m   = dpre + dhi + 1;
        mem = (op == OPC_LOAD || op == OPC_STORE);
        e.cycle = mem ? cyc + f + m : cyc + f + 1;
        e.vec   = model(op, f3, f7, flags);
        sb.push_back(e);
        for (int k = 0; k < f; k++) begin
            imem_busy = (k >= pre && k < pre + hi);
            @(posedge clock); #1;
        end
        imem_busy = 0;
        @(posedge clock); #1;
        if (mem) begin
            for (int k = 0; k < m; k++) begin
                dmem_busy = (k >= dpre && k < dpre + dhi);
                @(posedge clock); #1;
            end
            dmem_busy = 0;
        end else begin
            @(posedge clock); #1;
        end
    endtask

    task automatic illegal_run(input logic [6:0] op, input logic [2:0] f3, input string name);
        wait_fetch(0);
        opcode = op; funct3 = f3; funct7 = 7'd0;
        imem_busy = 1; @(posedge clock); #1;
        imem_busy = 0; @(posedge clock); #1;
        @(posedge clock); #1;
        check({name, "_flag"}, 64'(illegal), 64'(1));
        check({name, "_halt_outputs"}, 64'({obs64(), pce}), 64'(0));
        repeat (3) @(posedge clock);
        #1;
        check({name, "_absorbing"}, 64'({imem_en, illegal}), 64'(2'b01));
    endtask

    task automatic run32(input logic [6:0] op, input logic [2:0] f3,
                         input logic [9:0] want, input string name);
        reset32 = 0; imem_busy32 = 0; dmem_busy32 = 0;
        repeat (2) @(posedge clock);
        #1;
        reset32 = 1; opcode = op; funct3 = f3; funct7 = 7'd0;
        @(posedge clock); #1;
        imem_busy32 = 1; @(posedge clock); #1;
        imem_busy32 = 0; @(posedge clock); #1;
        @(posedge clock); #1;
        check(name, 64'({illegal32, imem_en32, dmem_en32, bwe32, rds32}), 64'(want));
    endtask

    function automatic logic [6:0] pick_op(input int i);
        case (i)
            0: return OPC_OP;      1: return OPC_OP_IMM;  2: return OPC_OP_32;
            3: return OPC_OP_IMM_32; 4: return OPC_LUI;   5: return OPC_AUIPC;
            6: return OPC_JAL;     7: return OPC_JALR;    8: return OPC_BRANCH;
            9: return OPC_LOAD;    default: return OPC_STORE;
        endcase
    endfunction

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation still running, want finished");
        $fatal(1);
    end

    initial begin : stimulus
        logic [6:0] op;
        logic [2:0] f3;
        reset = 0; reset32 = 0;
        opcode = 0; funct3 = 0; funct7 = 0;
        imem_busy = 0; dmem_busy = 0; imem_busy32 = 0; dmem_busy32 = 0;
        zero = 0; negative = 0; carry_out = 0; overflow = 0;

        do_reset();
        issue(OPC_OP,        3'b000, 7'h00, 4'b0000, 2, 3, 0, 1);  // ADD, busy cycles 2-4
        issue(OPC_BRANCH,    3'b100, 7'h00, 4'b0100, 0, 1, 0, 1);  // BLT taken
        issue(OPC_BRANCH,    3'b101, 7'h00, 4'b0100, 1, 1, 0, 1);  // BGE not taken
        issue(OPC_STORE,     3'b011, 7'h00, 4'b0000, 0, 1, 1, 2);  // SD
        issue(OPC_OP_IMM_32, 3'b000, 7'h00, 4'b0000, 0, 2, 0, 1);  // ADDIW
        issue(OPC_OP,        3'b101, 7'h20, 4'b0000, 0, 1, 0, 1);  // SRA
        issue(OPC_LOAD,      3'b100, 7'h00, 4'b0000, 0, 1, 2, 1);  // LBU
        issue(OPC_BRANCH,    3'b110, 7'h00, 4'b0010, 0, 1, 0, 1);  // BLTU with carry: not taken

        for (int i = 0; i < 60; i++) begin
            op = pick_op(int'($urandom_range(0, 10)));
            do begin
                f3 = 3'($urandom_range(0, 7));
            end while (op == OPC_BRANCH && f3[2:1] == 2'b01);
            issue(op, f3, 7'($urandom), 4'($urandom),
                  int'($urandom_range(0, 2)), int'($urandom_range(1, 3)),
                  int'($urandom_range(0, 2)), int'($urandom_range(1, 3)));
        end
        wait_fetch(0);
        check("scoreboard_drained", 64'(sb.size()), 64'(0));

        illegal_run(7'b0000010, 3'b000, "opc_0000010");
        do_reset();
        illegal_run(OPC_BRANCH, 3'b010, "branch_01x");
        do_reset();

        // Reset in the middle of a fetch handshake
        imem_busy = 1; @(posedge clock); #1;
        reset = 0; @(posedge clock); #1;
        check("mid_reset_drop", 64'({imem_en, dmem_en}), 64'(0));
        do_reset();
        issue(OPC_OP, 3'b000, 7'h00, 4'b0000, 2, 1, 0, 1);
        wait_fetch(0);
        check("post_mid_reset_drained", 64'(sb.size()), 64'(0));
        reset = 0;

        // RV32 legality: {illegal, imem_en, dmem_en, bwe[3:0], read_data_src}
        run32(OPC_STORE,     3'b011, {3'b100, 4'h0, 3'b000}, "rv32_sd");
        run32(OPC_LOAD,      3'b011, {3'b100, 4'h0, 3'b000}, "rv32_ld");
        run32(OPC_LOAD,      3'b110, {3'b100, 4'h0, 3'b000}, "rv32_lwu");
        run32(OPC_OP_IMM_32, 3'b000, {3'b100, 4'h0, 3'b000}, "rv32_addiw");
        run32(OPC_OP_32,     3'b000, {3'b100, 4'h0, 3'b000}, "rv32_addw");
        run32(OPC_LOAD,      3'b010, {3'b001, 4'h0, 3'b110}, "rv32_lw");
        run32(OPC_STORE,     3'b010, {3'b001, 4'hF, 3'b000}, "rv32_sw");
        run32(OPC_STORE,     3'b000, {3'b001, 4'h1, 3'b000}, "rv32_sb");

`ifdef CONTROL_UNIT_MEM_TIMEOUT_EN
        // Fetch with busy never asserted: HALT after 8 cycles in FETCH
        reset32 = 0; imem_busy32 = 0;
        repeat (2) @(posedge clock);
        #1;
        reset32 = 1;
        @(posedge clock); #1;
        for (int k = 0; k < 7; k++) begin
            @(posedge clock); #1;
        end
        check("timeout_last_fetch_cycle", 64'({imem_en32, mtimeout32}), 64'(2'b10));
        @(posedge clock); #1;
        check("timeout_halt", 64'({imem_en32, mtimeout32}), 64'(2'b01));
        reset32 = 0;
        @(posedge clock); #1;
        check("timeout_cleared", 64'(mtimeout32), 64'(0));
`endif
        reset32 = 0;
        @(posedge clock); #1;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
